// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin arbiter sharing one sdram_controller port.
// Optional watchdog abort is compiled in with `define SDRAM_ARB_WDOG_EN.
//
// Ports (all synchronous to clk = sdram_clock, res is active-high sync):
//   c_req/c_wr/c_addr/c_wdata/c_burst  packed per-client command inputs
//   c_ack/c_err                        one-cycle completion / abort pulses
//   c_grant                            one-hot owner, 0 when idle
//   c_rdata                            read data, valid with c_ack
//   m_req/m_wr/m_addr_in/m_data_in/m_burst  registered command to controller
//   m_ack/m_data_out                   completion + read data from controller
module sdram_port_arbiter #(
   parameter int NUM_CLIENTS = 4,
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 16,
   parameter int BURST_W     = 9,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                           clk,
   input  logic                           res,
   input  logic [NUM_CLIENTS-1:0]         c_req,
   input  logic [NUM_CLIENTS-1:0]         c_wr,
   input  logic [NUM_CLIENTS*ADDR_W-1:0]  c_addr,
   input  logic [NUM_CLIENTS*DATA_W-1:0]  c_wdata,
   input  logic [NUM_CLIENTS*BURST_W-1:0] c_burst,
   output logic [NUM_CLIENTS-1:0]         c_ack,
   output logic [NUM_CLIENTS-1:0]         c_err,
   output logic [NUM_CLIENTS-1:0]         c_grant,
   output logic [DATA_W-1:0]              c_rdata,
   output logic [ADDR_W-1:0]              m_addr_in,
   output logic [DATA_W-1:0]              m_data_in,
   output logic [BURST_W-1:0]             m_burst,
   output logic                           m_req,
   output logic                           m_wr,
   input  logic                           m_ack,
   input  logic [DATA_W-1:0]              m_data_out
);

   localparam int IDX_W = $clog2(NUM_CLIENTS);
   localparam logic [IDX_W-1:0] RR_INIT = IDX_W'(NUM_CLIENTS - 1);

   if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || TIMEOUT_CYC < 2) begin : g_param_check
      $error("sdram_port_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RELEASE
   } state_t;

   state_t                 state_q, state_n;
   logic [IDX_W-1:0]       rr_q, rr_n;
   logic [IDX_W-1:0]       win_q, win_n;

   logic                   m_req_n, m_wr_n;
   logic [ADDR_W-1:0]      m_addr_n;
   logic [DATA_W-1:0]      m_data_n;
   logic [BURST_W-1:0]     m_burst_n;
   logic [NUM_CLIENTS-1:0] c_ack_n, c_grant_n;
   logic [DATA_W-1:0]      c_rdata_n;

   // Round-robin scan: first requester strictly after rr, wrapping.
   logic                   found;
   logic [IDX_W-1:0]       win;
   logic [IDX_W:0]         sum;
   logic [IDX_W-1:0]       idx;

   always_comb begin
      found = 1'b0;
      win   = rr_q;
      sum   = '0;
      idx   = '0;
      for (int k = 1; k <= NUM_CLIENTS; k++) begin
         sum = {1'b0, rr_q} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_CLIENTS))
            sum = sum - (IDX_W+1)'(NUM_CLIENTS);
         idx = sum[IDX_W-1:0];
         if (!found && c_req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

`ifdef SDRAM_ARB_WDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]       cnt_q, cnt_n;
   logic [NUM_CLIENTS-1:0] c_err_n;
`endif

   always_comb begin
      state_n   = state_q;
      rr_n      = rr_q;
      win_n     = win_q;
      m_req_n   = m_req;
      m_wr_n    = m_wr;
      m_addr_n  = m_addr_in;
      m_data_n  = m_data_in;
      m_burst_n = m_burst;
      c_ack_n   = '0;
      c_grant_n = c_grant;
      c_rdata_n = c_rdata;
`ifdef SDRAM_ARB_WDOG_EN
      cnt_n     = cnt_q;
      c_err_n   = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_n   = S_ISSUE;
               rr_n      = win;
               win_n     = win;
               m_req_n   = 1'b1;
               m_wr_n    = c_wr[win];
               m_addr_n  = c_addr[win*ADDR_W +: ADDR_W];
               m_data_n  = c_wdata[win*DATA_W +: DATA_W];
               m_burst_n = c_burst[win*BURST_W +: BURST_W];
               c_grant_n = NUM_CLIENTS'(1) << win;
`ifdef SDRAM_ARB_WDOG_EN
               cnt_n     = '0;
`endif
            end
         end
         S_ISSUE: begin
            // m_ack takes priority over a same-cycle watchdog expiry.
            if (m_ack) begin
               state_n   = S_RELEASE;
               m_req_n   = 1'b0;
               c_ack_n   = NUM_CLIENTS'(1) << win_q;
               c_rdata_n = m_data_out;
            end
`ifdef SDRAM_ARB_WDOG_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_n = S_RELEASE;
               m_req_n = 1'b0;
               c_err_n = NUM_CLIENTS'(1) << win_q;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
`endif
         end
         S_RELEASE: begin
            // Gap cycle lets the client drop c_req before re-arbitration.
            state_n   = S_IDLE;
            c_grant_n = '0;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q   <= S_IDLE;
         rr_q      <= RR_INIT;
         win_q     <= '0;
         m_req     <= 1'b0;
         m_wr      <= 1'b0;
         m_addr_in <= '0;
         m_data_in <= '0;
         m_burst   <= '0;
         c_ack     <= '0;
         c_grant   <= '0;
         c_rdata   <= '0;
      end else begin
         state_q   <= state_n;
         rr_q      <= rr_n;
         win_q     <= win_n;
         m_req     <= m_req_n;
         m_wr      <= m_wr_n;
         m_addr_in <= m_addr_n;
         m_data_in <= m_data_n;
         m_burst   <= m_burst_n;
         c_ack     <= c_ack_n;
         c_grant   <= c_grant_n;
         c_rdata   <= c_rdata_n;
      end
   end

`ifdef SDRAM_ARB_WDOG_EN
   always_ff @(posedge clk) begin
      if (res) begin
         cnt_q <= '0;
         c_err <= '0;
      end else begin
         cnt_q <= cnt_n;
         c_err <= c_err_n;
      end
   end
`else
   assign c_err = '0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: scoreboard bench for sdram_port_arbiter.
// Issue/response expectations are queued by stimulus, checked by a monitor.
module tb_sdram_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 24;
   localparam int DW = 16;
   localparam int BW = 9;

   logic            clk = 1'b0;
   logic            res;
   logic [N-1:0]    c_req, c_wr;
   logic [N*AW-1:0] c_addr;
   logic [N*DW-1:0] c_wdata;
   logic [N*BW-1:0] c_burst;
   logic [N-1:0]    c_ack, c_err, c_grant;
   logic [DW-1:0]   c_rdata;
   logic [AW-1:0]   m_addr_in;
   logic [DW-1:0]   m_data_in;
   logic [BW-1:0]   m_burst;
   logic            m_req, m_wr, m_ack;
   logic [DW-1:0]   m_data_out;

   always #5 clk = ~clk;

   sdram_port_arbiter #(
      .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW),
      .BURST_W(BW), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .res(res),
      .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr),
      .c_wdata(c_wdata), .c_burst(c_burst),
      .c_ack(c_ack), .c_err(c_err), .c_grant(c_grant),
      .c_rdata(c_rdata),
      .m_addr_in(m_addr_in), .m_data_in(m_data_in),
      .m_burst(m_burst), .m_req(m_req), .m_wr(m_wr),
      .m_ack(m_ack), .m_data_out(m_data_out)
   );

   typedef struct {
      logic [N-1:0]  grant;
      logic [AW-1:0] addr;
      logic          wr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] burst;
   } iss_t;

   typedef struct {
      logic [N-1:0]  mask;
      logic [DW-1:0] rdata;
      logic          is_err;
   } rsp_t;

   iss_t iq[$];
   rsp_t rq[$];

   int n_chk   = 0;
   int n_fail  = 0;
   int ack_cnt = 0;
   int cyc     = 0;

   logic          ack_en    = 1'b1;
   int            ack_delay = 5;
   logic [DW-1:0] ack_data  = '0;
   logic          stray     = 1'b0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got event expected none", name);
   endtask

   task automatic step(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic set_client(int i, logic wr, logic [AW-1:0] a,
                             logic [DW-1:0] d, logic [BW-1:0] b);
      c_wr[i] = wr;
      c_addr[i*AW +: AW] = a;
      c_wdata[i*DW +: DW] = d;
      c_burst[i*BW +: BW] = b;
   endtask

   function automatic iss_t mk_iss(int i, logic wr, logic [AW-1:0] a,
                                   logic [DW-1:0] d, logic [BW-1:0] b);
      iss_t s;
      s.grant = N'(1) << i;
      s.addr  = a;
      s.wr    = wr;
      s.wdata = d;
      s.burst = b;
      return s;
   endfunction

   function automatic rsp_t mk_rsp(int i, logic [DW-1:0] d, logic e);
      rsp_t r;
      r.mask   = N'(1) << i;
      r.rdata  = d;
      r.is_err = e;
      return r;
   endfunction

   task automatic wait_rsp(int n, int budget);
      int target;
      int b;
      target = ack_cnt + n;
      b = 0;
      while (ack_cnt < target && b < budget) begin
         step(1);
         b++;
      end
      if (ack_cnt < target) flag("rsp_timeout");
   endtask

   // SDRAM controller model: acks ack_delay cycles after m_req rises.
   initial begin
      int cnt;
      cnt = 0;
      m_ack = 1'b0;
      m_data_out = '0;
      forever begin
         @(negedge clk);
         m_ack = stray;
         if (m_req && ack_en) begin
            cnt++;
            if (cnt == ack_delay) begin
               m_ack = 1'b1;
               m_data_out = ack_data;
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor: checks every issue and every ack/err against the queues.
   initial begin
      logic          prev_req;
      logic [N-1:0]  prev_rsp;
      logic [DW-1:0] prev_rd;
      int            rise_cyc;
      iss_t          s;
      rsp_t          r;
      prev_req = 1'b0;
      prev_rsp = '0;
      prev_rd  = '0;
      rise_cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (res) begin
            prev_req = 1'b0;
            prev_rsp = '0;
         end else begin
            if (m_req && !prev_req) begin
               rise_cyc = cyc;
               if (iq.size() == 0) flag("unexpected_issue");
               else begin
                  s = iq.pop_front();
                  chk("issue_grant", 64'(c_grant), 64'(s.grant));
                  chk("issue_addr", 64'(m_addr_in), 64'(s.addr));
                  chk("issue_wr", 64'(m_wr), 64'(s.wr));
                  if (s.wr) chk("issue_wdata", 64'(m_data_in), 64'(s.wdata));
                  chk("issue_burst", 64'(m_burst), 64'(s.burst));
               end
            end
            if (c_ack != '0 || c_err != '0) begin
               chk("ack_err_excl", 64'(c_ack != '0 && c_err != '0), 64'(0));
               if (rq.size() == 0) flag("unexpected_rsp");
               else begin
                  r = rq.pop_front();
                  if (r.is_err) begin
                     chk("err_mask", 64'(c_err), 64'(r.mask));
                     chk("err_ack_low", 64'(c_ack), 64'(0));
                     chk("err_latency", 64'(cyc - rise_cyc), 64'(16));
                     chk("err_rdata_hold", 64'(c_rdata), 64'(prev_rd));
                  end else begin
                     chk("ack_mask", 64'(c_ack), 64'(r.mask));
                     chk("ack_rdata", 64'(c_rdata), 64'(r.rdata));
                  end
               end
               ack_cnt++;
            end
            if (prev_rsp != '0)
               chk("release_grant_clear", 64'(c_grant), 64'(0));
            prev_req = m_req;
            prev_rsp = c_ack | c_err;
            prev_rd  = c_rdata;
         end
      end
   end

   initial begin
      res = 1'b1;
      c_req = '0;
      c_wr = '0;
      c_addr = '0;
      c_wdata = '0;
      c_burst = '0;
      step(2);
      chk("rst_m_req", 64'(m_req), 64'(0));
      chk("rst_m_wr", 64'(m_wr), 64'(0));
      chk("rst_grant", 64'(c_grant), 64'(0));
      chk("rst_ack", 64'(c_ack), 64'(0));
      chk("rst_err", 64'(c_err), 64'(0));
      chk("rst_addr", 64'(m_addr_in), 64'(0));
      chk("rst_data", 64'(m_data_in), 64'(0));
      chk("rst_burst", 64'(m_burst), 64'(0));
      chk("rst_rdata", 64'(c_rdata), 64'(0));
      res = 1'b0;
      step(1);

      // Client 1 read, acked after 5 cycles with 0xBEEF.
      set_client(1, 1'b0, 24'h000100, 16'h0000, 9'd8);
      ack_delay = 5;
      ack_data = 16'hBEEF;
      iq.push_back(mk_iss(1, 1'b0, 24'h000100, 16'h0000, 9'd8));
      rq.push_back(mk_rsp(1, 16'hBEEF, 1'b0));
      c_req[1] = 1'b1;
      step(1);
      chk("req_latency", 64'(m_req), 64'(1));
      chk("req_grant", 64'(c_grant), 64'(4'b0010));
      wait_rsp(1, 30);
      c_req[1] = 1'b0;
      step(4);

      // Clients 0 and 2 after reset: 0 first, then 2.
      res = 1'b1;
      step(2);
      res = 1'b0;
      set_client(0, 1'b0, 24'h0000A0, 16'h0000, 9'd4);
      set_client(2, 1'b1, 24'h0000C0, 16'h1234, 9'd1);
      ack_delay = 3;
      ack_data = 16'h1111;
      iq.push_back(mk_iss(0, 1'b0, 24'h0000A0, 16'h0000, 9'd4));
      iq.push_back(mk_iss(2, 1'b1, 24'h0000C0, 16'h1234, 9'd1));
      rq.push_back(mk_rsp(0, 16'h1111, 1'b0));
      rq.push_back(mk_rsp(2, 16'h2222, 1'b0));
      c_req[0] = 1'b1;
      c_req[2] = 1'b1;
      wait_rsp(1, 30);
      c_req[0] = 1'b0;
      ack_data = 16'h2222;
      wait_rsp(1, 30);
      c_req[2] = 1'b0;
      step(4);

      // All four hold requests: 0,1,2,3 three times.
      res = 1'b1;
      step(2);
      res = 1'b0;
      ack_delay = 2;
      ack_data = 16'hA5A5;
      for (int i = 0; i < N; i++)
         set_client(i, 1'b0, AW'(24'h000010 * (i + 1)), 16'h0000, BW'(i + 1));
      for (int t = 0; t < 12; t++) begin
         iq.push_back(mk_iss(t % N, 1'b0, AW'(24'h000010 * (t % N + 1)),
                             16'h0000, BW'(t % N + 1)));
         rq.push_back(mk_rsp(t % N, 16'hA5A5, 1'b0));
      end
      c_req = '1;
      wait_rsp(12, 300);
      c_req = '0;
      step(4);

      // Client 3 write, reset mid-ISSUE, then 0 and 3 contend.
      ack_en = 1'b0;
      set_client(3, 1'b1, 24'h000200, 16'h5678, 9'h1FF);
      iq.push_back(mk_iss(3, 1'b1, 24'h000200, 16'h5678, 9'h1FF));
      c_req[3] = 1'b1;
      step(4);
      res = 1'b1;
      step(1);
      chk("midrst_m_req", 64'(m_req), 64'(0));
      chk("midrst_grant", 64'(c_grant), 64'(0));
      chk("midrst_ack", 64'(c_ack), 64'(0));
      res = 1'b0;
      ack_en = 1'b1;
      ack_delay = 3;
      ack_data = 16'h0A0A;
      set_client(0, 1'b0, 24'h000300, 16'h0000, 9'd2);
      iq.push_back(mk_iss(0, 1'b0, 24'h000300, 16'h0000, 9'd2));
      iq.push_back(mk_iss(3, 1'b1, 24'h000200, 16'h5678, 9'h1FF));
      rq.push_back(mk_rsp(0, 16'h0A0A, 1'b0));
      rq.push_back(mk_rsp(3, 16'h0A0A, 1'b0));
      c_req[0] = 1'b1;
      wait_rsp(1, 30);
      c_req[0] = 1'b0;
      wait_rsp(1, 30);
      c_req[3] = 1'b0;
      step(4);

      // Client 0 drops c_req during ISSUE.
      ack_delay = 6;
      ack_data = 16'h0F0F;
      set_client(0, 1'b0, 24'h000400, 16'h0000, 9'd3);
      iq.push_back(mk_iss(0, 1'b0, 24'h000400, 16'h0000, 9'd3));
      rq.push_back(mk_rsp(0, 16'h0F0F, 1'b0));
      c_req[0] = 1'b1;
      step(3);
      c_req[0] = 1'b0;
      wait_rsp(1, 30);
      step(6);
      chk("drop_no_regrant_req", 64'(m_req), 64'(0));
      chk("drop_no_regrant_grant", 64'(c_grant), 64'(0));

      // Stray m_ack while idle.
      stray = 1'b1;
      step(1);
      stray = 1'b0;
      step(1);
      chk("stray_no_ack", 64'(c_ack), 64'(0));
      chk("stray_no_req", 64'(m_req), 64'(0));
      step(2);

`ifdef SDRAM_ARB_WDOG_EN
      // Watchdog: controller never acks.
      ack_en = 1'b0;
      set_client(2, 1'b0, 24'h000333, 16'h0000, 9'd5);
      iq.push_back(mk_iss(2, 1'b0, 24'h000333, 16'h0000, 9'd5));
      rq.push_back(mk_rsp(2, 16'h0000, 1'b1));
      c_req[2] = 1'b1;
      wait_rsp(1, 40);
      c_req[2] = 1'b0;
      chk("wdog_m_req", 64'(m_req), 64'(0));
      step(2);
      chk("wdog_idle_grant", 64'(c_grant), 64'(0));
      ack_en = 1'b1;
      step(2);
`endif

      chk("iq_drained", 64'(iq.size()), 64'(0));
      chk("rq_drained", 64'(rq.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
